pkt_arbiter: RTL and testbench
==============================

PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, number of packet sources (2..4, fixed source-id width 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16, stall cycles before forced release (timeout build only).
REQ-003 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, NUM_SRC, per-source beat valid.
REQ-006 The block SHALL have port in_ready, output, NUM_SRC, per-source beat accept.
REQ-007 The block SHALL have port in_beat, input, NUM_SRC x 13, per-source {dst_addr[1:0], p_type[1:0], payload[7:0], eop}.
REQ-008 The block SHALL have port out_valid, output, 1, output beat valid.
REQ-009 The block SHALL have port out_ready, input, 1, downstream accept.
REQ-010 The block SHALL have port out_beat, output, 13, forwarded beat, same field layout.
REQ-011 The block SHALL have port out_src, output, 2, source id of out_beat.
REQ-012 The block SHALL have port busy, output, 1, high while a packet holds the grant.
REQ-013 The block SHALL have port err_timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-014 The block SHALL implement states IDLE and XFER; busy = (state == XFER).
REQ-015 In IDLE, in_ready SHALL be all zero; if any in_valid is high, the block SHALL register grant = round-robin winner searching upward from ptr+1 (wrapping) and enter XFER next cycle.
REQ-016 In XFER, only in_ready[grant] SHALL be asserted, equal to (!out_valid || out_ready); all others 0.
REQ-017 A beat SHALL transfer when in_valid[grant] && in_ready[grant]; it loads out_beat/out_src and sets out_valid the next cycle.
REQ-018 out_valid SHALL clear when out_ready is high and no new beat loads that cycle; out_beat SHALL stay stable while out_valid && !out_ready.
REQ-019 Latency: request in IDLE at cycle N -> first beat accepted cycle N+1 -> out_valid cycle N+2; subsequent beats at one per cycle when out_ready is held high.
REQ-020 The grant SHALL be held from first beat until a beat with eop=1 transfers; then state -> IDLE and ptr <= grant.
REQ-021 Exactly one idle cycle SHALL separate packets (eop transfer cycle -> IDLE -> next XFER); requests arriving during the eop cycle are arbitrated in that IDLE cycle.
REQ-022 A single-beat packet (eop on first beat) SHALL be legal and handled per REQ-020.
REQ-023 Sources deasserting in_valid mid-packet SHALL keep the grant (non-timeout build); the output register drains normally.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, grant=0, ptr=NUM_SRC-1 (source 0 wins first), out_valid=0, out_beat=0, out_src=0, in_ready=0, busy=0, err_timeout=0, stall counter=0.
REQ-025 Reset mid-packet SHALL discard the partial packet and any buffered beat; no recovery of it after reset.

Configuration
REQ-026 With PKT_ARB_TIMEOUT_EN defined, a counter SHALL increment each XFER cycle with in_valid[grant]=0 (reset on any transfer; out_ready stalls do not count); on reaching TIMEOUT_CYC: state -> IDLE, ptr <= grant, err_timeout=1 for one cycle.
REQ-027 Without PKT_ARB_TIMEOUT_EN, no counter SHALL exist, err_timeout SHALL be tied 0, and the grant is held indefinitely.

Structure
REQ-028 Shared package pkt_pkg SHALL hold arb_state_t enum (IDLE, XFER), pkt_beat_t packed struct (dst_addr, p_type, payload, eop), and SRC_ID_W=2.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_arbiter (req, ptr -> winner, any_req), instantiated once.

Verification
REQ-030 After reset, in_valid=4'b1111, all 1-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0 with one idle cycle between beats.
REQ-031 Src2 sends 3-beat packet (payload 0x11,0x22,0x33, eop on 3rd) while src0 requests -> out beats 0x11,0x22,0x33 with out_src=2 contiguous, then src0 granted.
REQ-032 out_ready=0 for 5 cycles mid-packet -> out_beat held stable, in_ready[grant]=0, no beat lost or duplicated, resume at 1 beat/cycle.
REQ-033 rst_n pulsed low during beat 2 of a 4-beat packet -> out_valid=0 immediately; next grant goes to source 0 if requesting.
REQ-034 PKT_ARB_TIMEOUT_EN, TIMEOUT_CYC=16: granted source drops in_valid after beat 1 -> err_timeout pulses on the 16th stall cycle, next requester granted; without macro the grant holds 100+ cycles, err_timeout=0.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types for the packet arbiter slice.
//   SRC_ID_W    : width of a source id (fixed at 2, up to four sources)
//   arb_state_t : arbiter FSM states (IDLE, XFER)
//   pkt_beat_t  : one beat, {dst_addr, p_type, payload, eop}, eop in bit 0
//   BEAT_W      : packed width of pkt_beat_t
package pkt_pkg;

   localparam int unsigned SRC_ID_W = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [1:0] dst_addr;
      logic [1:0] p_type;
      logic [7:0] payload;
      logic       eop;
   } pkt_beat_t;

   localparam int unsigned BEAT_W = $bits(pkt_beat_t);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req     : per-source request vector
//   ptr     : last granted source; search starts at ptr+1 and wraps
//   winner  : first requesting source found (0 when none)
//   any_req : at least one request is present
module rr_arbiter
   import pkt_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]  req,
   input  logic [SRC_ID_W-1:0] ptr,
   output logic [SRC_ID_W-1:0] winner,
   output logic                any_req
);

   always_comb begin
      int unsigned idx;
      idx     = 0;
      winner  = '0;
      any_req = 1'b0;
      // i = NUM_SRC revisits ptr itself, so the last owner still wins when alone
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         if (!any_req && req[idx]) begin
            winner  = SRC_ID_W'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pkt_arbiter.sv
// Packet-level round-robin arbiter: one source owns the output from its first
// beat until its eop beat, with a single registered output stage.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/ready   : per-source beat handshake
//   in_beat          : per-source beats, source s at [s*BEAT_W +: BEAT_W]
//   out_valid/ready  : output beat handshake
//   out_beat/out_src : forwarded beat and its source id
//   busy             : a packet currently holds the grant
//   err_timeout      : one-cycle pulse when a stalled grant is forcibly released
// Build option: define PKT_ARB_TIMEOUT_EN to release a grant whose source has
// not offered a beat for TIMEOUT_CYC cycles; otherwise the grant is held.
module pkt_arbiter
   import pkt_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        in_valid,
   output logic [NUM_SRC-1:0]        in_ready,
   input  logic [NUM_SRC*BEAT_W-1:0] in_beat,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BEAT_W-1:0]         out_beat,
   output logic [SRC_ID_W-1:0]       out_src,
   output logic                      busy,
   output logic                      err_timeout
);

   arb_state_t          state_q, state_d;
   logic [SRC_ID_W-1:0] grant_q, grant_d;
   logic [SRC_ID_W-1:0] ptr_q, ptr_d;
   logic [SRC_ID_W-1:0] winner;
   logic                any_req;
   logic                out_valid_q, out_valid_d;
   pkt_beat_t           out_beat_q, out_beat_d;
   logic [SRC_ID_W-1:0] out_src_q, out_src_d;
   pkt_beat_t           beat_sel;
   logic                cur_valid;
   logic                can_load;
   logic                xfer;
   logic                force_rel;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_rr_arbiter (
      .req     (in_valid),
      .ptr     (ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   // Mux the granted source's beat and valid
   always_comb begin
      beat_sel  = '0;
      cur_valid = 1'b0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         if (grant_q == SRC_ID_W'(s)) begin
            beat_sel  = pkt_beat_t'(in_beat[s*BEAT_W +: BEAT_W]);
            cur_valid = in_valid[s];
         end
      end
   end

   // Output register can take a beat when empty or draining this cycle
   assign can_load = !out_valid_q || out_ready;
   assign xfer     = (state_q == XFER) && cur_valid && can_load;

   always_comb begin
      in_ready = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         in_ready[s] = (state_q == XFER) && (grant_q == SRC_ID_W'(s)) && can_load;
      end
   end

`ifdef PKT_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q;

   // Counts only cycles where the owner offers nothing; output back-pressure
   // neither advances nor clears the count.
   always_comb begin
      cnt_d     = cnt_q;
      force_rel = 1'b0;
      if (state_q != XFER || xfer) begin
         cnt_d = '0;
      end else if (!cur_valid) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            cnt_d     = '0;
            force_rel = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= force_rel;
      end
   end

   assign err_timeout = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign force_rel          = 1'b0;
   assign err_timeout        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = winner;
               state_d = XFER;
            end
         end
         XFER: begin
            if ((xfer && beat_sel.eop) || force_rel) begin
               state_d = IDLE;
               ptr_d   = grant_q;
            end
         end
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_beat_d  = out_beat_q;
      out_src_d   = out_src_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_beat_d  = beat_sel;
         out_src_d   = grant_q;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ptr_q       <= SRC_ID_W'(NUM_SRC - 1);
         out_valid_q <= 1'b0;
         out_beat_q  <= '0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_beat_q  <= out_beat_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_beat  = out_beat_q;
   assign out_src   = out_src_q;
   assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed self-checking bench for pkt_arbiter (NUM_SRC=4, TIMEOUT_CYC=16).
// Per-source packet queues feed the inputs; a monitor logs every accepted
// output beat with its cycle number for ordering and spacing checks.
module tb_pkt_arbiter;

   localparam int NS = 4;

   typedef struct {
      int         cyc;
      logic [1:0] src;
      logic [12:0] beat;
   } rec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NS-1:0]   in_valid;
   logic [NS-1:0]   in_ready;
   logic [NS*13-1:0] in_beat;
   logic            out_valid;
   logic            out_ready;
   logic [12:0]     out_beat;
   logic [1:0]      out_src;
   logic            busy;
   logic            err_timeout;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          base;
   logic [NS-1:0] fire = '0;
   logic [12:0] srcq [NS][$];
   rec_t        rx[$];

   pkt_arbiter #(
      .NUM_SRC     (NS),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_beat     (in_beat),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_beat    (out_beat),
      .out_src     (out_src),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sources: pop on an accepted beat, then present the queue head
   always @(posedge clk) begin
      #1;
      for (int s = 0; s < NS; s++) begin
         if (fire[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
         if (srcq[s].size() > 0) begin
            in_valid[s]         = 1'b1;
            in_beat[s*13 +: 13] = srcq[s][0];
         end else begin
            in_valid[s]         = 1'b0;
            in_beat[s*13 +: 13] = '0;
         end
      end
   end

   always @(negedge clk) begin
      fire <= in_valid & in_ready;
      if (rst_n && out_valid && out_ready) rx.push_back(rec_t'{cyc, out_src, out_beat});
   end

   function automatic logic [12:0] mk(input logic [1:0] dst, input logic [7:0] pl,
                                      input logic eop);
      return {dst, 2'b01, pl, eop};
   endfunction

   task automatic wait_rx(input int n, input int budget, input string what);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         k++;
      end while ((rx.size() - base) < n && k < budget);
      checks++;
      if ((rx.size() - base) < n) begin
         errors++;
         $display("FAIL %s: timed out with %0d beats, required %0d", what, rx.size() - base, n);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = '0;
      in_beat   = '0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
      checks++; if (out_beat !== 13'h0) begin errors++; $display("FAIL rst_out_beat: got %h want 0", out_beat); end
      checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL rst_out_src: got %0d want 0", out_src); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // All four request single-beat packets; source 0 has a second one queued
   task automatic test_round_robin();
      int t0;
      logic [1:0] exp_src [5];
      logic [7:0] exp_pl [5];
      exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_pl  = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h05};
      base = rx.size();
      @(negedge clk);
      t0 = cyc;
      srcq[0].push_back(mk(2'd0, 8'h01, 1'b1));
      srcq[0].push_back(mk(2'd0, 8'h05, 1'b1));
      srcq[1].push_back(mk(2'd1, 8'h11, 1'b1));
      srcq[2].push_back(mk(2'd2, 8'h21, 1'b1));
      srcq[3].push_back(mk(2'd3, 8'h31, 1'b1));
      wait_rx(5, 60, "rr_wait");
      // in_valid seen in cycle t0+1, beat accepted t0+2, out_valid t0+3
      checks++;
      if (rx[base].cyc !== t0 + 3) begin
         errors++; $display("FAIL rr_latency: got cycle %0d want %0d", rx[base].cyc, t0 + 3);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rx[base+i].src !== exp_src[i] || rx[base+i].beat !== mk(exp_src[i], exp_pl[i], 1'b1)) begin
            errors++;
            $display("FAIL rr_beat%0d: got src %0d beat %h want src %0d beat %h", i,
                     rx[base+i].src, rx[base+i].beat, exp_src[i], mk(exp_src[i], exp_pl[i], 1'b1));
         end
      end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (rx[base+i].cyc - rx[base+i-1].cyc !== 2) begin
            errors++; $display("FAIL rr_gap%0d: got %0d cycles want 2", i,
                               rx[base+i].cyc - rx[base+i-1].cyc);
         end
      end
   endtask

   // ptr is 0 here, so src2 beats src0 and keeps the grant for all three beats
   task automatic test_multi_beat();
      logic [12:0] exp_b [4];
      logic [1:0]  exp_s [4];
      exp_b = '{mk(2'd2, 8'h11, 1'b0), mk(2'd2, 8'h22, 1'b0), mk(2'd2, 8'h33, 1'b1),
                mk(2'd0, 8'h55, 1'b1)};
      exp_s = '{2'd2, 2'd2, 2'd2, 2'd0};
      base = rx.size();
      @(negedge clk);
      for (int i = 0; i < 3; i++) srcq[2].push_back(exp_b[i]);
      srcq[0].push_back(exp_b[3]);
      wait_rx(4, 60, "multi_wait");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rx[base+i].src !== exp_s[i] || rx[base+i].beat !== exp_b[i]) begin
            errors++; $display("FAIL multi_beat%0d: got src %0d beat %h want src %0d beat %h", i,
                               rx[base+i].src, rx[base+i].beat, exp_s[i], exp_b[i]);
         end
      end
      checks++;
      if (rx[base+1].cyc - rx[base].cyc !== 1 || rx[base+2].cyc - rx[base+1].cyc !== 1) begin
         errors++; $display("FAIL multi_contig: got gaps %0d,%0d want 1,1",
                            rx[base+1].cyc - rx[base].cyc, rx[base+2].cyc - rx[base+1].cyc);
      end
      checks++;
      if (rx[base+3].cyc - rx[base+2].cyc !== 2) begin
         errors++; $display("FAIL multi_next: got gap %0d want 2", rx[base+3].cyc - rx[base+2].cyc);
      end
   endtask

   task automatic test_backpressure();
      logic [12:0] held;
      int          bad;
      held = mk(2'd1, 8'hA2, 1'b0);
      bad  = 0;
      base = rx.size();
      @(negedge clk);
      for (int i = 0; i < 4; i++) srcq[1].push_back(mk(2'd1, 8'hA1 + 8'(i), 1'b0 + (i == 3)));
      wait_rx(1, 40, "bp_first");
      #1 out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_beat !== held || in_ready !== 4'b0000) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL bp_hold: got %0d bad stall cycles (last valid %b beat %h ready %b) want 0",
                            bad, out_valid, out_beat, in_ready);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_rx(4, 40, "bp_wait");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rx[base+i].src !== 2'd1 || rx[base+i].beat !== mk(2'd1, 8'hA1 + 8'(i), 1'b0 + (i == 3))) begin
            errors++; $display("FAIL bp_beat%0d: got src %0d beat %h want src 1 beat %h", i,
                               rx[base+i].src, rx[base+i].beat, mk(2'd1, 8'hA1 + 8'(i), 1'b0 + (i == 3)));
         end
      end
      checks++;
      if (rx[base+1].cyc - rx[base].cyc !== 6 || rx[base+2].cyc - rx[base+1].cyc !== 1 ||
          rx[base+3].cyc - rx[base+2].cyc !== 1) begin
         errors++; $display("FAIL bp_timing: got gaps %0d,%0d,%0d want 6,1,1",
                            rx[base+1].cyc - rx[base].cyc, rx[base+2].cyc - rx[base+1].cyc,
                            rx[base+3].cyc - rx[base+2].cyc);
      end
   endtask

   task automatic test_reset_mid_packet();
      base = rx.size();
      @(negedge clk);
      for (int i = 0; i < 4; i++) srcq[3].push_back(mk(2'd3, 8'hC1 + 8'(i), 1'b0 + (i == 3)));
      wait_rx(1, 40, "rstmid_first");
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
         errors++; $display("FAIL rstmid_clear: got valid %b busy %b ready %b want 0 0 0000",
                            out_valid, busy, in_ready);
      end
      @(negedge clk);
      for (int s = 0; s < NS; s++) srcq[s].delete();
      srcq[0].push_back(mk(2'd0, 8'h5A, 1'b1));
      srcq[3].push_back(mk(2'd3, 8'h3B, 1'b1));
      base = rx.size();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_rx(2, 40, "rstmid_wait");
      checks++;
      if (rx[base].src !== 2'd0 || rx[base].beat !== mk(2'd0, 8'h5A, 1'b1)) begin
         errors++; $display("FAIL rstmid_src0: got src %0d beat %h want src 0 beat %h",
                            rx[base].src, rx[base].beat, mk(2'd0, 8'h5A, 1'b1));
      end
      checks++;
      if (rx[base+1].src !== 2'd3 || rx[base+1].beat !== mk(2'd3, 8'h3B, 1'b1)) begin
         errors++; $display("FAIL rstmid_src3: got src %0d beat %h want src 3 beat %h",
                            rx[base+1].src, rx[base+1].beat, mk(2'd3, 8'h3B, 1'b1));
      end
   endtask

   // src2 offers one non-eop beat and goes quiet; src1 then requests
   task automatic test_stalled_source();
      int bad;
      int pulses;
      int err_cyc;
      bad     = 0;
      pulses  = 0;
      err_cyc = -1;
      base = rx.size();
      @(negedge clk);
      srcq[2].push_back(mk(2'd2, 8'h61, 1'b0));
      wait_rx(1, 40, "stall_first");
      @(negedge clk);
      srcq[1].push_back(mk(2'd1, 8'h71, 1'b1));
`ifdef PKT_ARB_TIMEOUT_EN
      repeat (40) begin
         @(negedge clk);
         if (err_timeout === 1'b1) begin
            pulses++;
            if (err_cyc < 0) err_cyc = cyc;
         end
      end
      checks++;
      if (pulses !== 1) begin
         errors++; $display("FAIL to_pulses: got %0d pulses want 1", pulses);
      end
      // out_valid of the 0x61 beat is the first stall cycle
      checks++;
      if (err_cyc - rx[base].cyc !== 16) begin
         errors++; $display("FAIL to_timing: got err %0d cycles after beat want 16",
                            err_cyc - rx[base].cyc);
      end
      wait_rx(2, 40, "to_wait");
      checks++;
      if (rx[base+1].src !== 2'd1 || rx[base+1].beat !== mk(2'd1, 8'h71, 1'b1)) begin
         errors++; $display("FAIL to_next: got src %0d beat %h want src 1 beat %h",
                            rx[base+1].src, rx[base+1].beat, mk(2'd1, 8'h71, 1'b1));
      end
`else
      repeat (120) begin
         @(negedge clk);
         if (busy !== 1'b1 || err_timeout !== 1'b0 || in_ready[1] !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0 || rx.size() - base !== 1) begin
         errors++; $display("FAIL hold_grant: got %0d bad cycles and %0d beats want 0 and 1",
                            bad, rx.size() - base);
      end
      @(negedge clk);
      srcq[2].push_back(mk(2'd2, 8'h62, 1'b1));
      wait_rx(3, 40, "hold_wait");
      checks++;
      if (rx[base+1].src !== 2'd2 || rx[base+1].beat !== mk(2'd2, 8'h62, 1'b1)) begin
         errors++; $display("FAIL hold_eop: got src %0d beat %h want src 2 beat %h",
                            rx[base+1].src, rx[base+1].beat, mk(2'd2, 8'h62, 1'b1));
      end
      checks++;
      if (rx[base+2].src !== 2'd1 || rx[base+2].beat !== mk(2'd1, 8'h71, 1'b1)) begin
         errors++; $display("FAIL hold_next: got src %0d beat %h want src 1 beat %h",
                            rx[base+2].src, rx[base+2].beat, mk(2'd1, 8'h71, 1'b1));
      end
`endif
   endtask

   initial begin
      base = 0;
      test_reset();
      test_round_robin();
      test_multi_beat();
      test_backpressure();
      test_reset_mid_packet();
      test_stalled_source();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
